// File: rtl/prog_fetch.sv
// Program counter and 2^ADDR_W x 16 program memory, loaded through a byte-serial bootstrap port.
// Define PROG_CHECKSUM_EN to add a trailing checksum byte and drive boot_err from the comparison.
module prog_fetch #(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        pc_inc,
   input  logic        pc_load,
   input  logic [11:0] pc_next,
   input  logic        boot_req,
   input  logic [7:0]  boot_byte,
   input  logic        boot_valid,
   output logic        boot_ready,
   output logic        bootstrapping,
   output logic [15:0] instruction,
   output logic [11:0] pc,
   output logic        boot_err
);

   typedef enum logic [2:0] {
      RUN,
      LEN_HI,
      LEN_LO,
      WR_HI,
      WR_LO
`ifdef PROG_CHECKSUM_EN
      , CHK
`endif
   } state_t;

`ifdef PROG_CHECKSUM_EN
   localparam state_t LAST_ST = CHK;
`else
   localparam state_t LAST_ST = RUN;
`endif

   state_t              state_q, state_d;
   logic [11:0]         pc_q, pc_d;
   logic [ADDR_W-1:0]   wptr_q, wptr_d;
   logic [15:0]         count_q, count_d;
   logic [7:0]          hi_q, hi_d;
   logic                mem_we;
   logic                xfer;
   logic [15:0]         mem [2**ADDR_W];

   assign xfer = boot_valid && (state_q != RUN);

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q <= RUN;
         pc_q    <= 12'h000;
         wptr_q  <= '0;
         count_q <= 16'h0000;
         hi_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         hi_q    <= hi_d;
      end
   end

   // Memory contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wptr_q] <= {hi_q, boot_byte};
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:    if (boot_req) state_d = LEN_HI;
         LEN_HI: if (xfer) state_d = LEN_LO;
         LEN_LO: if (xfer) state_d = ({count_q[15:8], boot_byte} == 16'h0000) ? LAST_ST : WR_HI;
         WR_HI:  if (xfer) state_d = WR_LO;
         WR_LO:  if (xfer) state_d = (count_q == 16'h0001) ? LAST_ST : WR_HI;
`ifdef PROG_CHECKSUM_EN
         CHK:    if (xfer) state_d = RUN;
`endif
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      pc_d    = pc_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      hi_d    = hi_q;
      mem_we  = 1'b0;
      case (state_q)
         RUN: begin
            if (boot_req) begin
               pc_d   = 12'h000;
               wptr_d = '0;
            end else if (pc_load) begin
               pc_d = pc_next;
            end else if (pc_inc) begin
               pc_d = pc_q + 12'd1;
            end
         end
         LEN_HI: if (xfer) count_d = {boot_byte, 8'h00};
         LEN_LO: if (xfer) count_d = {count_q[15:8], boot_byte};
         WR_HI:  if (xfer) hi_d = boot_byte;
         WR_LO: begin
            if (xfer) begin
               mem_we  = 1'b1;
               wptr_d  = wptr_q + ADDR_W'(1);
               count_d = count_q - 16'd1;
            end
         end
         default: ;
      endcase
   end

`ifdef PROG_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
   logic       boot_err_q, boot_err_d;

   // Only data bytes feed the sum; the flag is cleared when a new load starts.
   always_comb begin
      sum_d      = sum_q;
      boot_err_d = boot_err_q;
      if (state_q == RUN && boot_req) begin
         sum_d      = 8'h00;
         boot_err_d = 1'b0;
      end else if (xfer && (state_q == WR_HI || state_q == WR_LO)) begin
         sum_d = sum_q + boot_byte;
      end else if (xfer && state_q == CHK) begin
         boot_err_d = (boot_byte != sum_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         sum_q      <= 8'h00;
         boot_err_q <= 1'b0;
      end else begin
         sum_q      <= sum_d;
         boot_err_q <= boot_err_d;
      end
   end
`endif

   always_comb begin
      boot_ready    = (state_q != RUN);
      bootstrapping = (state_q != RUN);
      instruction   = (state_q != RUN) ? 16'h0000 : mem[pc_q[ADDR_W-1:0]];
      pc            = pc_q;
`ifdef PROG_CHECKSUM_EN
      boot_err      = boot_err_q;
`else
      boot_err      = 1'b0;
`endif
   end

endmodule

// File: tb/tb_prog_fetch.sv
// Scoreboard bench for prog_fetch: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_prog_fetch;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        pc_inc = 1'b0;
   logic        pc_load = 1'b0;
   logic [11:0] pc_next = 12'h000;
   logic        boot_req = 1'b0;
   logic [7:0]  boot_byte = 8'h00;
   logic        boot_valid = 1'b0;
   logic        boot_ready;
   logic        bootstrapping;
   logic [15:0] instruction;
   logic [11:0] pc;
   logic        boot_err;

   prog_fetch #(.ADDR_W(8)) dut (
      .clk(clk),
      .arst_n(arst_n),
      .pc_inc(pc_inc),
      .pc_load(pc_load),
      .pc_next(pc_next),
      .boot_req(boot_req),
      .boot_byte(boot_byte),
      .boot_valid(boot_valid),
      .boot_ready(boot_ready),
      .bootstrapping(bootstrapping),
      .instruction(instruction),
      .pc(pc),
      .boot_err(boot_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [11:0] pc;
      logic [15:0] instr;
      logic        chk_instr;
      logic        boot;
      logic        ready;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   checks = 0;
   int   failures = 0;
   logic sample_en = 1'b0;
   logic ok;

   // Monitor: whenever the stimulus side flags an observation point, pop the
   // oldest expectation and compare it against what the DUT presents.
   always @(negedge clk) begin
      if (sample_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_underflow: observation with no expected entry");
         end else begin
            cur = exp_q.pop_front();
            ok = (pc === cur.pc) && (bootstrapping === cur.boot) &&
                 (boot_ready === cur.ready) && (boot_err === cur.err) &&
                 (!cur.chk_instr || instruction === cur.instr);
            if (!ok) begin
               failures++;
               $display("[TB] FAIL %s: got pc=%h instr=%h boot=%b ready=%b err=%b, expected pc=%h instr=%h(chk=%b) boot=%b ready=%b err=%b",
                        cur.name, pc, instruction, bootstrapping, boot_ready, boot_err,
                        cur.pc, cur.instr, cur.chk_instr, cur.boot, cur.ready, cur.err);
            end
         end
      end
   end

   // Global watchdog so a stuck DUT can never hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue an expectation and flag the monitor for the upcoming falling edge.
   task automatic checkOutput(input string name, input logic [11:0] e_pc, input logic [15:0] e_instr,
                              input logic e_chk_instr, input logic e_boot, input logic e_ready,
                              input logic e_err);
      exp_t e;
      e.name = name;
      e.pc = e_pc;
      e.instr = e_instr;
      e.chk_instr = e_chk_instr;
      e.boot = e_boot;
      e.ready = e_ready;
      e.err = e_err;
      exp_q.push_back(e);
      sample_en = 1'b1;
      @(negedge clk);
      #1;
      sample_en = 1'b0;
   endtask

   // Drive the PC controls for exactly one clock.
   task automatic applyStimulus(input logic inc, input logic load, input logic [11:0] nxt);
      pc_inc = inc;
      pc_load = load;
      pc_next = nxt;
      tick();
      pc_inc = 1'b0;
      pc_load = 1'b0;
   endtask

   // Present one byte until it is accepted; optionally leave a idle cycle after it.
   task automatic sendByte(input logic [7:0] b, input bit gap);
      int waited = 0;
      boot_byte = b;
      boot_valid = 1'b1;
      while (!boot_ready && waited < 20) begin
         tick();
         waited++;
      end
      if (!boot_ready) begin
         checks++;
         failures++;
         $display("[TB] FAIL boot_ready_timeout: got ready=%b, expected 1 within 20 cycles", boot_ready);
      end
      tick();
      boot_valid = 1'b0;
      if (gap) tick();
   endtask

   task automatic startBoot();
      boot_req = 1'b1;
      tick();
      boot_req = 1'b0;
   endtask

   // Two-word image 0x1012, 0x3005; data byte sum is 0x57.
   task automatic sendImage(input bit gap, input logic [7:0] csum);
      sendByte(8'h00, gap);
      sendByte(8'h02, gap);
      sendByte(8'h10, gap);
      sendByte(8'h12, gap);
      sendByte(8'h30, gap);
      sendByte(8'h05, gap);
`ifdef PROG_CHECKSUM_EN
      sendByte(csum, gap);
`else
      if (csum != csum) sendByte(csum, gap);
`endif
   endtask

   initial begin
      $display("[TB] prog_fetch scoreboard bench starting");

      // Reset state; memory is uninitialised so instruction is not checked.
      tick();
      tick();
      arst_n = 1'b1;
      checkOutput("reset", 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Normal load with pc_inc held high to show it is ignored while loading.
      pc_inc = 1'b1;
      startBoot();
      checkOutput("boot_start", 12'h000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
      sendImage(1'b0, 8'h57);
      checkOutput("boot_done", 12'h000, 16'h1012, 1'b1, 1'b0, 1'b0, 1'b0);
      pc_inc = 1'b0;

      // PC sequencing, load priority and wraparound.
      applyStimulus(1'b1, 1'b0, 12'h000);
      checkOutput("pc_inc_1", 12'h001, 16'h3005, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 12'h000);
      applyStimulus(1'b1, 1'b0, 12'h000);
      checkOutput("pc_inc_3", 12'h003, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 12'h000);
      checkOutput("pc_hold", 12'h003, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 12'h0A5);
      checkOutput("pc_load_priority", 12'h0A5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 12'hFFF);
      checkOutput("pc_load_fff", 12'hFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 12'h000);
      checkOutput("pc_wrap", 12'h000, 16'h1012, 1'b1, 1'b0, 1'b0, 1'b0);

      // Load again with boot_valid toggling every cycle.
      startBoot();
      sendImage(1'b1, 8'h57);
      checkOutput("toggle_done", 12'h000, 16'h1012, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 12'h000);
      checkOutput("toggle_word1", 12'h001, 16'h3005, 1'b1, 1'b0, 1'b0, 1'b0);

      // Zero-length load returns to RUN with memory untouched.
      startBoot();
      sendByte(8'h00, 1'b0);
      sendByte(8'h00, 1'b0);
`ifdef PROG_CHECKSUM_EN
      checkOutput("n0_in_chk", 12'h000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
      sendByte(8'h00, 1'b0);
`endif
      checkOutput("n0_done", 12'h000, 16'h1012, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 12'h000);
      checkOutput("n0_word1", 12'h001, 16'h3005, 1'b1, 1'b0, 1'b0, 1'b0);

      // Reset after the first data byte aborts the load and keeps memory.
      startBoot();
      sendByte(8'h00, 1'b0);
      sendByte(8'h01, 1'b0);
      sendByte(8'hAB, 1'b0);
      checkOutput("mid_boot", 12'h000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
      arst_n = 1'b0;
      tick();
      arst_n = 1'b1;
      checkOutput("abort_reset", 12'h000, 16'h1012, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 12'h000);
      checkOutput("abort_word1", 12'h001, 16'h3005, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef PROG_CHECKSUM_EN
      // Wrong checksum raises a sticky error that only the next load clears.
      startBoot();
      sendImage(1'b0, 8'h00);
      checkOutput("bad_csum", 12'h000, 16'h1012, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 12'h000);
      checkOutput("bad_csum_sticky", 12'h001, 16'h3005, 1'b1, 1'b0, 1'b0, 1'b1);
      startBoot();
      checkOutput("err_cleared", 12'h000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
      arst_n = 1'b0;
      tick();
      arst_n = 1'b1;
`endif

      tick();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
